// File: rtl/seq_addsub.sv
// ---------------------------------------------------------------------------
// seq_addsub
//
// Multi-cycle adder/subtractor. One accepted request adds (or subtracts) two
// WIDTH-bit operands CHUNK bits per clock, least-significant chunk first, and
// rippling the carry between chunks through a register.
//
// Parameters
//   WIDTH  operand/result width in bits (an integer multiple of CHUNK)
//   CHUNK  bits added per clock; N = WIDTH/CHUNK clocks per operation
//
// Ports
//   clk    single clock, all state on the rising edge
//   reset  asynchronous, active-high; aborts any operation without a done
//   start  request, sampled only while idle
//   sub    0: a + b, 1: a - b (sampled with start)
//   a, b   operands (sampled with start)
//   busy   high whenever the block is not idle
//   done   one-cycle pulse marking y and flags valid
//   y      result, held until the next accepted start
//   cout   carry out of the MSB (subtract: 1 means no borrow)
//   ovf    two's-complement overflow
//   zero   result equals zero
//
// Build option
//   SEQ_ADDSUB_FLAGS_EN  defined: cout/ovf/zero are computed.
//                        undefined: cout/ovf/zero are tied to 0 and no flag
//                        logic is built; y, done, busy and timing unchanged.
//
// Timing: start accepted at edge E0, chunk i written at edge E(i+1),
// done is high for the single cycle after EN, busy from after E0 through it.
// ---------------------------------------------------------------------------
module seq_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / CHUNK;
    // Keep the counter at least one bit wide so N == 1 still elaborates.
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;     // already inverted for subtraction
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] y_nxt;
    logic             last;
    logic             accept;

    // ------------------------------------------------------------------
    // Control: state register and next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign last   = (cnt == CW'(N - 1));
    assign accept = (state == ST_IDLE) && start;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (last)  state_nxt = ST_DONE;
            ST_DONE:            state_nxt = ST_IDLE;
            default:            state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    // ------------------------------------------------------------------
    // Chunk select and add. The counter picks the active chunk; constant
    // part-selects inside the loop keep the muxing explicit.
    // ------------------------------------------------------------------
    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt == CW'(i)) begin
                chunk_a = op_a[i*CHUNK +: CHUNK];
                chunk_b = op_b[i*CHUNK +: CHUNK];
            end
        end
    end

    assign sum = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry};

    always_comb begin
        y_nxt = y;
        for (int i = 0; i < N; i++) begin
            if (cnt == CW'(i)) begin
                y_nxt[i*CHUNK +: CHUNK] = sum[CHUNK-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand capture and result accumulation
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            y     <= '0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1: invert b here, seed the carry with 1.
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            y     <= y_nxt;
            carry <= sum[CHUNK];
            cnt   <= cnt + CW'(1);
        end
    end

`ifdef SEQ_ADDSUB_FLAGS_EN
    // ------------------------------------------------------------------
    // Flags, captured together with the final chunk so they stay aligned
    // with y from done until the next accepted start.
    // ------------------------------------------------------------------
    logic cout_r;
    logic ovf_r;
    logic zero_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else if ((state == ST_RUN) && last) begin
            cout_r <= sum[CHUNK];
            // op_b holds the effective (possibly inverted) operand, so its
            // MSB is the sign that actually entered the adder.
            ovf_r  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                      (y_nxt[WIDTH-1] != op_a[WIDTH-1]);
            zero_r <= (y_nxt == '0);
        end
    end

    assign cout = cout_r;
    assign ovf  = ovf_r;
    assign zero = zero_r;
`else
    assign cout = 1'b0;
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_addsub.sv
// ---------------------------------------------------------------------------
// tb_seq_addsub
//
// Directed bench for seq_addsub. Two instances: dut (WIDTH=32, CHUNK=8) and
// dut1 (WIDTH=32, CHUNK=32). Expected flag values are zero when the build
// leaves SEQ_ADDSUB_FLAGS_EN undefined.
// ---------------------------------------------------------------------------
module tb_seq_addsub;

    localparam int W = 32;
`ifdef SEQ_ADDSUB_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         start1;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;

    logic         busy,  done,  cout,  ovf,  zero;
    logic [W-1:0] y;
    logic         busy1, done1, cout1, ovf1, zero1;
    logic [W-1:0] y1;

    // Outputs of whichever instance the current vector targets.
    logic         sel;
    logic         m_busy, m_done, m_cout, m_ovf, m_zero;
    logic [W-1:0] m_y;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_addsub #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .y(y), .cout(cout), .ovf(ovf), .zero(zero)
    );

    seq_addsub #(.WIDTH(32), .CHUNK(32)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .sub(sub), .a(a), .b(b),
        .busy(busy1), .done(done1), .y(y1), .cout(cout1), .ovf(ovf1), .zero(zero1)
    );

    always_comb begin
        m_busy = sel ? busy1 : busy;
        m_done = sel ? done1 : done;
        m_y    = sel ? y1    : y;
        m_cout = sel ? cout1 : cout;
        m_ovf  = sel ? ovf1  : ovf;
        m_zero = sel ? zero1 : zero;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full operation: drive, scramble operands while busy, measure the
    // number of cycles until done, then check result, flags and the single pulse.
    task automatic run_op(input bit u, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input bit isub, input int exp_lat, input logic [W-1:0] ey,
                          input bit ec, input bit eo, input bit ez, input string tag);
        int lat;
        logic [W-1:0] y_seen;
        sel = u;
        @(negedge clk);
        a = ia; b = ib; sub = isub;
        if (u) start1 = 1'b1; else start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; start1 = 1'b0;
        a = $urandom; b = $urandom; sub = 1'($urandom);
        chk({tag, " busy"}, 64'(m_busy), 64'(1));
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            if (m_done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        chk({tag, " lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, " y"}, 64'(m_y), 64'(ey));
        chk({tag, " cout"}, 64'(m_cout), 64'(FL & ec));
        chk({tag, " ovf"}, 64'(m_ovf), 64'(FL & eo));
        chk({tag, " zero"}, 64'(m_zero), 64'(FL & ez));
        y_seen = m_y;
        @(negedge clk);
        chk({tag, " pulse"}, 64'(m_done), 64'(0));
        chk({tag, " idle"}, 64'(m_busy), 64'(0));
        chk({tag, " hold"}, 64'(m_y), 64'(y_seen));
    endtask

    initial begin
        int ndone;
        reset = 1'b1; start = 1'b0; start1 = 1'b0; sub = 1'b0;
        a = '0; b = '0; sel = 1'b0;

        // Reset state
        #12;
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst done", 64'(done), 64'(0));
        chk("rst y", 64'(y), 64'(0));
        chk("rst cout", 64'(cout), 64'(0));
        chk("rst ovf", 64'(ovf), 64'(0));
        chk("rst zero", 64'(zero), 64'(0));
        chk("rst busy1", 64'(busy1), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        // Carry through every chunk and wrap to zero
        run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 5, 32'h0000_0000, 1, 0, 1, "ff+1");
        // Positive overflow
        run_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 5, 32'h8000_0000, 0, 1, 0, "max+1");
        // Subtract with borrow
        run_op(1'b0, 32'h0000_0005, 32'h0000_0007, 1'b1, 5, 32'hFFFF_FFFE, 0, 0, 0, "5-7");
        // Subtract without borrow
        run_op(1'b0, 32'h0000_0007, 32'h0000_0005, 1'b1, 5, 32'h0000_0002, 1, 0, 0, "7-5");
        // Negative overflow on subtract
        run_op(1'b0, 32'h8000_0000, 32'h0000_0001, 1'b1, 5, 32'h7FFF_FFFF, 1, 1, 0, "min-1");
        // Carry between alternate chunks only
        run_op(1'b0, 32'h00FF_00FF, 32'h0001_0001, 1'b0, 5, 32'h0100_0100, 0, 0, 0, "chunkc");
        // No carries at all
        run_op(1'b0, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 5, 32'h2143_6587, 0, 0, 0, "plain");

        // Start pulses during RUN and DONE are ignored
        sel = 1'b0;
        @(negedge clk);
        a = 32'h1111_1111; b = 32'h2222_2222; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; sub = 1'b1;
        ndone = 0;
        for (int k = 3; k <= 14; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                ndone++;
                start = 1'b1; a = 32'h0000_0005; b = 32'h0000_0009;
            end
        end
        start = 1'b0;
        chk("ign ndone", 64'(ndone), 64'(1));
        chk("ign y", 64'(y), 64'(32'h3333_3333));
        chk("ign busy", 64'(busy), 64'(0));

        // Reset asserted after two chunks aborts the operation
        @(negedge clk);
        a = 32'h0101_0101; b = 32'h0202_0202; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("abort busy", 64'(busy), 64'(0));
        chk("abort y", 64'(y), 64'(0));
        chk("abort done", 64'(done), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort nodone", 64'(ndone), 64'(0));
        run_op(1'b0, 32'h0000_0003, 32'h0000_0004, 1'b0, 5, 32'h0000_0007, 0, 0, 0, "3+4");

        // Single-chunk instance
        run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 2, 32'h0000_0000, 1, 1, 1, "n1 min+min");
        run_op(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1, 2, 32'hFFFF_FFFE, 0, 0, 0, "n1 5-7");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
